// File: rtl/cpu5arm_pkg.sv
// Shared definitions for the 5-stage LEGv8 core: pipeline sequencer state
// encoding, the zero-register index, decode opcodes, the bubble instruction
// and the bundle of pipeline-register controls the sequencer drives.
package cpu5arm_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEMWAIT  = 2'd1,
      ST_LDSTALL  = 2'd2,
      ST_REDIRECT = 2'd3
   } pipe_state_e;

   localparam logic [4:0]  XZR      = 5'd31;

   localparam logic [10:0] OP_LDUR  = 11'b11010000000;
   localparam logic [10:0] OP_STUR  = 11'b11010000001;
   localparam logic [7:0]  OP_CBZ   = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
   localparam logic [7:0]  OP_BCOND = 8'b01010100;

   // ADD XZR, XZR, XZR: no architectural effect, used as the pipeline bubble
   localparam logic [31:0] NOP_INSN = 32'h8B1F03FF;

   typedef struct packed {
      logic pc_we;
      logic pc_sel_tgt;
      logic ifid_we;
      logic ifid_flush;
      logic idex_we;
      logic idex_bubble;
      logic exmem_we;
   } pipe_ctl_t;

   //                                    pc  tgt ifid flsh idex bub exmem
   localparam pipe_ctl_t CTL_RUN    = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};
   localparam pipe_ctl_t CTL_FREEZE = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam pipe_ctl_t CTL_BRANCH = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1};
   localparam pipe_ctl_t CTL_LDUSE  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
   localparam pipe_ctl_t CTL_RESET  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0};

endpackage

// File: rtl/cpu5arm_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
//   clk_i   : clock, rising edge
//   clr_n_i : synchronous clear, active low (wins over inc_i)
//   inc_i   : count up by one this cycle
//   cnt_o   : current count, sticks at all-ones
module cpu5arm_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         clr_n_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!clr_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu5arm_pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage LEGv8 core. Produces stage
// enables, IF/ID flush and ID/EX bubble for load-use hazards, taken-branch
// redirects and variable-latency data memory accesses, plus saturating
// stall / flush counters.
//   clk, reset (sync, active low)
//   id_*  : ID-stage source registers and their use flags
//   ex_*  : EX-stage destination and load flag
//   mem_valid / dmem_ack : data memory access in MEM and its completion
//   br_taken : branch resolved taken in MEM
//   pc_we .. exmem_we : pipeline register controls
//   dmem_req : data memory request
//   state : sequencer state (RUN/MEMWAIT/LDSTALL/REDIRECT)
//   stall_cnt / flush_cnt : saturating performance counters
module cpu5arm_pipe_ctrl
   import cpu5arm_pkg::*;
#(
   parameter int         CNT_W           = 16,
   parameter int         REDIRECT_CYCLES = 1,
   parameter logic [4:0] XZR_IDX         = XZR
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rn,
   input  logic [4:0]       id_rm,
   input  logic             id_use_rn,
   input  logic             id_use_rm,
   input  logic             ex_valid,
   input  logic             ex_is_load,
   input  logic [4:0]       ex_rd,
   input  logic             mem_valid,
   input  logic             dmem_ack,
   input  logic             br_taken,
   output logic             pc_we,
   output logic             pc_sel_tgt,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_bubble,
   output logic             exmem_we,
   output logic             dmem_req,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [2:0] RC_INIT = 3'(REDIRECT_CYCLES);

   pipe_state_e state_q, state_d;
   logic [2:0]  rc_q, rc_d;
   pipe_ctl_t   ctl;
   logic        freeze, load_use, in_redirect, lu_eff;
   logic        stall_inc, flush_inc;

   assign freeze   = mem_valid & ~dmem_ack;
   assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != XZR_IDX) &
                     ((id_use_rn & (id_rn == ex_rd)) | (id_use_rm & (id_rm == ex_rd)));

   // While a redirect is pending (including one parked behind a memory wait)
   // ID only holds flushed slots, so a hazard seen there is meaningless and
   // must not knock the sequencer out of its redirect countdown.
   assign in_redirect = (state_q == ST_REDIRECT) |
                        ((state_q == ST_MEMWAIT) & (rc_q != 3'd0));
   assign lu_eff      = load_use & ~in_redirect;

   always_comb begin
      ctl       = CTL_RUN;
      state_d   = state_q;
      rc_d      = rc_q;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      if (freeze) begin
         // rc holds so a redirect interrupted by the wait resumes intact
         ctl       = CTL_FREEZE;
         state_d   = ST_MEMWAIT;
         stall_inc = 1'b1;
      end else if (br_taken) begin
         ctl       = CTL_BRANCH;
         state_d   = ST_REDIRECT;
         rc_d      = RC_INIT;
         flush_inc = 1'b1;
      end else if (lu_eff) begin
         ctl       = CTL_LDUSE;
         state_d   = ST_LDSTALL;
         stall_inc = 1'b1;
      end else begin
         unique case (state_q)
            ST_MEMWAIT:  state_d = (rc_q != 3'd0) ? ST_REDIRECT : ST_RUN;
            ST_REDIRECT: begin
               ctl.ifid_flush = 1'b1;
               rc_d    = (rc_q != 3'd0) ? rc_q - 3'd1 : 3'd0;
               state_d = (rc_q <= 3'd1) ? ST_RUN : ST_REDIRECT;
            end
            default:     state_d = ST_RUN;
         endcase
      end
      if (!reset) begin
         ctl       = CTL_RESET;
         state_d   = ST_RUN;
         rc_d      = 3'd0;
         stall_inc = 1'b0;
         flush_inc = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_RUN;
         rc_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
      end
   end

   cpu5arm_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk),
      .clr_n_i (reset),
      .inc_i   (stall_inc),
      .cnt_o   (stall_cnt)
   );

   cpu5arm_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk),
      .clr_n_i (reset),
      .inc_i   (flush_inc),
      .cnt_o   (flush_cnt)
   );

   assign pc_we       = ctl.pc_we;
   assign pc_sel_tgt  = ctl.pc_sel_tgt;
   assign ifid_we     = ctl.ifid_we;
   assign ifid_flush  = ctl.ifid_flush;
   assign idex_we     = ctl.idex_we;
   assign idex_bubble = ctl.idex_bubble;
   assign exmem_we    = ctl.exmem_we;
   assign dmem_req    = reset & mem_valid;
   assign state       = state_q;

endmodule

// File: tb/tb_cpu5arm_pipe_ctrl.sv
// Bench for cpu5arm_pipe_ctrl (CNT_W=4, REDIRECT_CYCLES=2). Each vector is
// driven on the falling edge and its expected outputs are queued; a checker
// pops and compares them shortly afterwards, before the next rising edge.
module tb_cpu5arm_pipe_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_use_rn, id_use_rm, ex_valid, ex_is_load;
   logic [4:0] id_rn, id_rm, ex_rd;
   logic       mem_valid, dmem_ack, br_taken;
   logic       pc_we, pc_sel_tgt, ifid_we, ifid_flush, idex_we, idex_bubble;
   logic       exmem_we, dmem_req;
   logic [1:0] state;
   logic [3:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   cpu5arm_pipe_ctrl #(.CNT_W(4), .REDIRECT_CYCLES(2), .XZR_IDX(5'd31)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
      .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .mem_valid(mem_valid), .dmem_ack(dmem_ack), .br_taken(br_taken),
      .pc_we(pc_we), .pc_sel_tgt(pc_sel_tgt), .ifid_we(ifid_we),
      .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_bubble(idex_bubble),
      .exmem_we(exmem_we), .dmem_req(dmem_req), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // outs = {pc_we, pc_sel_tgt, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, dmem_req}
   localparam logic [7:0] O_RST = 8'b0001_1100;
   localparam logic [7:0] O_RUN = 8'b1010_1010;
   localparam logic [7:0] O_ACK = 8'b1010_1011;
   localparam logic [7:0] O_LU  = 8'b0000_1110;
   localparam logic [7:0] O_FRZ = 8'b0000_0001;
   localparam logic [7:0] O_BR  = 8'b1111_1110;
   localparam logic [7:0] O_BRQ = 8'b1111_1111;
   localparam logic [7:0] O_RDR = 8'b1011_1010;

   typedef struct {
      logic       rst, idv;
      logic [4:0] rn, rm;
      logic       urn, urm, exv, ld;
      logic [4:0] rd;
      logic       mv, ack, br;
      logic [7:0] o;
      logic [1:0] st;
      logic [3:0] sc, fc;
      int         tag;
   } vec_t;

   vec_t sbq[$];
   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;
   int   nvec   = 0;

   logic [7:0] act_o;
   assign act_o = {pc_we, pc_sel_tgt, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, dmem_req};

   function automatic vec_t mk(input logic rst, input logic idv, input logic [4:0] rn,
                               input logic [4:0] rm, input logic urn, input logic urm,
                               input logic exv, input logic ld, input logic [4:0] rd,
                               input logic mv, input logic ack, input logic br,
                               input logic [7:0] o, input logic [1:0] st,
                               input logic [3:0] sc, input logic [3:0] fc);
      vec_t v;
      v.rst = rst; v.idv = idv; v.rn = rn; v.rm = rm; v.urn = urn; v.urm = urm;
      v.exv = exv; v.ld = ld; v.rd = rd; v.mv = mv; v.ack = ack; v.br = br;
      v.o = o; v.st = st; v.sc = sc; v.fc = fc; v.tag = 0;
      return v;
   endfunction

   // no ID/EX activity
   function automatic vec_t mz(input logic rst, input logic mv, input logic ack,
                               input logic br, input logic [7:0] o, input logic [1:0] st,
                               input logic [3:0] sc, input logic [3:0] fc);
      return mk(rst, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, mv, ack, br, o, st, sc, fc);
   endfunction

   task automatic step(input vec_t v);
      @(negedge clk);
      reset = v.rst; id_valid = v.idv; id_rn = v.rn; id_rm = v.rm;
      id_use_rn = v.urn; id_use_rm = v.urm; ex_valid = v.exv; ex_is_load = v.ld;
      ex_rd = v.rd; mem_valid = v.mv; dmem_ack = v.ack; br_taken = v.br;
      v.tag = nvec;
      nvec++;
      sbq.push_back(v);
   endtask

   task automatic cmp(input string nm, input int tag, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec%0d: got %b expected %b", nm, tag, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (sbq.size() > 0) begin
            vec_t e;
            e = sbq.pop_front();
            cmp("outs",  e.tag, act_o, e.o);
            cmp("state", e.tag, {6'd0, state}, {6'd0, e.st});
            cmp("stall_cnt", e.tag, {4'd0, stall_cnt}, {4'd0, e.sc});
            cmp("flush_cnt", e.tag, {4'd0, flush_cnt}, {4'd0, e.fc});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; id_valid = 1'b0; id_rn = 5'd0; id_rm = 5'd0; id_use_rn = 1'b0;
      id_use_rm = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
      mem_valid = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
      repeat (2) @(posedge clk);

      // reset, load-use, XZR, single rm hazard, freeze, branch, branch+load-use
      tbl.push_back(mz(0, 0, 0, 0, O_RST, 0, 0, 0));
      tbl.push_back(mz(1, 0, 0, 0, O_RUN, 0, 0, 0));
      tbl.push_back(mk(1, 1, 11, 0, 1, 0, 1, 1, 11, 0, 0, 0, O_LU,  0, 0, 0));
      tbl.push_back(mk(1, 1, 11, 0, 1, 0, 0, 0, 0,  1, 1, 0, O_ACK, 2, 1, 0));
      tbl.push_back(mk(1, 1, 31, 0, 1, 0, 1, 1, 31, 0, 0, 0, O_RUN, 0, 1, 0));
      tbl.push_back(mk(1, 1, 5,  5, 0, 1, 1, 1, 5,  0, 0, 0, O_LU,  0, 1, 0));
      tbl.push_back(mk(1, 1, 5,  5, 0, 0, 1, 1, 5,  0, 0, 0, O_RUN, 2, 2, 0));
      tbl.push_back(mk(1, 1, 5,  5, 1, 1, 1, 0, 5,  0, 0, 0, O_RUN, 0, 2, 0));
      tbl.push_back(mk(1, 0, 5,  5, 1, 1, 1, 1, 5,  0, 0, 0, O_RUN, 0, 2, 0));
      tbl.push_back(mz(1, 1, 0, 0, O_FRZ, 0, 2, 0));
      tbl.push_back(mz(1, 1, 0, 0, O_FRZ, 1, 3, 0));
      tbl.push_back(mz(1, 1, 0, 0, O_FRZ, 1, 4, 0));
      tbl.push_back(mz(1, 1, 1, 0, O_ACK, 1, 5, 0));
      tbl.push_back(mz(1, 0, 1, 0, O_RUN, 0, 5, 0));
      tbl.push_back(mz(1, 0, 0, 1, O_BR,  0, 5, 0));
      tbl.push_back(mz(1, 0, 0, 0, O_RDR, 3, 5, 1));
      tbl.push_back(mz(1, 0, 0, 0, O_RDR, 3, 5, 1));
      tbl.push_back(mz(1, 0, 0, 0, O_RUN, 0, 5, 1));
      tbl.push_back(mk(1, 1, 11, 0, 1, 0, 1, 1, 11, 0, 0, 1, O_BR, 0, 5, 1));
      tbl.push_back(mz(1, 0, 0, 0, O_RDR, 3, 5, 2));
      tbl.push_back(mz(1, 0, 0, 0, O_RDR, 3, 5, 2));
      tbl.push_back(mz(1, 0, 0, 0, O_RUN, 0, 5, 2));
      foreach (tbl[i]) step(tbl[i]);

      // branch held during a freeze: ignored until the ack cycle
      step(mz(1, 1, 0, 1, O_FRZ, 0, 5, 2));
      step(mz(1, 1, 1, 1, O_BRQ, 1, 6, 2));
      step(mz(1, 0, 0, 0, O_RDR, 3, 6, 3));
      step(mz(1, 0, 0, 0, O_RDR, 3, 6, 3));
      step(mz(1, 0, 0, 0, O_RUN, 0, 6, 3));

      // memory wait inside a redirect resumes it with rc preserved
      step(mz(1, 0, 0, 1, O_BR,  0, 6, 3));
      step(mz(1, 1, 0, 0, O_FRZ, 3, 6, 4));
      step(mz(1, 1, 1, 0, O_ACK, 1, 7, 4));
      step(mz(1, 0, 0, 0, O_RDR, 3, 7, 4));
      step(mz(1, 0, 0, 0, O_RDR, 3, 7, 4));
      step(mz(1, 0, 0, 0, O_RUN, 0, 7, 4));

      // new branch during redirect restarts the countdown
      step(mz(1, 0, 0, 1, O_BR,  0, 7, 4));
      step(mz(1, 0, 0, 0, O_RDR, 3, 7, 5));
      step(mz(1, 0, 0, 1, O_BR,  3, 7, 5));
      step(mz(1, 0, 0, 0, O_RDR, 3, 7, 6));
      step(mz(1, 0, 0, 0, O_RDR, 3, 7, 6));
      step(mz(1, 0, 0, 0, O_RUN, 0, 7, 6));

      // stall counter saturation over a long freeze
      for (int i = 0; i < 20; i++) begin
         int s;
         s = (7 + i > 15) ? 15 : 7 + i;
         step(mz(1, 1, 0, 0, O_FRZ, (i == 0) ? 2'd0 : 2'd1, 4'(s), 6));
      end

      // reset in the middle of a memory wait
      step(mz(0, 1, 0, 0, O_RST, 1, 15, 6));
      step(mz(0, 1, 0, 0, O_RST, 0, 0, 0));
      step(mz(1, 0, 0, 0, O_RUN, 0, 0, 0));

      repeat (2) @(negedge clk);
      #4;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu5arm_pipe_ctrl.md
Name: cpu5arm_pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage LEGv8 core (IF, ID, EX, MEM, WB). It generates stage-enable, bubble and flush controls, and covers three cases:
- load-use hazards
- taken-branch redirects
- variable-latency data memory accesses, using a req/ack handshake on the daddrbus/databus side.

It also keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt
REDIRECT_CYCLES, 1, extra cycles the IF/ID register stays flushed after a redirect (fetch latency), legal range 1..7
XZR_IDX, 31, register index that never creates a hazard

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rn  in  5  ID source register 1
id_rm  in  5  ID source register 2
id_use_rn  in  1  ID instruction reads id_rn
id_use_rm  in  1  ID instruction reads id_rm
ex_valid  in  1  EX stage holds a real instruction
ex_is_load  in  1  EX instruction is LDUR
ex_rd  in  5  EX destination register
mem_valid  in  1  MEM stage holds LDUR or STUR
dmem_ack  in  1  data memory completes the current access this cycle
br_taken  in  1  branch/CB resolved taken in MEM this cycle
pc_we  out  1  PC register write enable
pc_sel_tgt  out  1  PC mux selects the branch target
ifid_we  out  1  IF/ID enable
ifid_flush  out  1  IF/ID loads a NOP
idex_we  out  1  ID/EX enable
idex_bubble  out  1  ID/EX loads a NOP
exmem_we  out  1  EX/MEM and MEM/WB enable
dmem_req  out  1  data memory request
state  out  2  FSM state: RUN=0, MEMWAIT=1, LDSTALL=2, REDIRECT=3
stall_cnt  out  CNT_W  stalled cycles, saturating
flush_cnt  out  CNT_W  taken redirects, saturating

Behaviour:
- The FSM state, the redirect down-counter rc (3 bits) and both counters are registered. All other outputs are combinational from state and inputs.

Reset:
- While reset==0 at a clock edge: state becomes RUN, rc=0, stall_cnt=0, flush_cnt=0.
- While reset==0, the outputs are forced to: pc_we=0, pc_sel_tgt=0, ifid_we=0, ifid_flush=1, idex_we=1, idex_bubble=1, exmem_we=0, dmem_req=0.
- Reset asserted mid-MEMWAIT abandons the access; dmem_req drops in the same cycle.

Derived terms:
- load_use = id_valid & ex_valid & ex_is_load & (ex_rd!=XZR_IDX) & ((id_use_rn & id_rn==ex_rd) | (id_use_rm & id_rm==ex_rd))
- freeze = mem_valid & !dmem_ack
- dmem_req = mem_valid (outside reset)

Priority, evaluated each cycle in any state: freeze > br_taken > load_use > normal.

- freeze:
  - All enables 0 (pc_we, ifid_we, idex_we, exmem_we); no flush and no bubble.
  - Next state MEMWAIT. rc holds.
  - stall_cnt+1.
  - Other inputs are ignored; the frozen pipe keeps them stable until the ack.
- br_taken (not frozen):
  - pc_we=1, pc_sel_tgt=1, ifid_flush=1, idex_bubble=1, all enables 1.
  - Next state REDIRECT, rc=REDIRECT_CYCLES.
  - flush_cnt+1.
  - An older load_use in the same cycle is discarded because its instruction is squashed.
- load_use (not frozen, no branch):
  - pc_we=0, ifid_we=0, idex_bubble=1, exmem_we=1.
  - Next state LDSTALL.
  - stall_cnt+1.
  - Exactly one bubble is inserted per hazard: in the following cycle the load has moved to MEM, so load_use is false.
- normal: all enables 1, no flush, no bubble.

Per-state rules when none of the above applies:
- MEMWAIT: on dmem_ack, behave as the first cycle of RUN (the acked cycle advances normally); next state RUN, or REDIRECT if rc!=0.
- LDSTALL: behaves as RUN; next state RUN.
- REDIRECT:
  - ifid_flush=1 and rc-1 each cycle.
  - At rc==1 the next state is RUN.
  - A new br_taken restarts rc=REDIRECT_CYCLES and counts +1.
  - load_use is impossible here because ID is flushed; treat it as don't-care.

Other rules:
- A MEMWAIT entered during REDIRECT resumes REDIRECT after the ack, with rc preserved.
- dmem_ack without mem_valid is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.

Decomposition:
- Shared package cpu5arm_pkg:
  - state encoding constants (RUN, MEMWAIT, LDSTALL, REDIRECT)
  - XZR index
  - opcode constants (LDUR 11'b11010000000, STUR 11'b11010000001, CBZ/CBNZ/B.cond)
  - NOP encoding
- One sub-module, cpu5arm_sat_counter (width param, inc, sync active-low clear), instantiated twice.
- Hazard comparison stays inline.

Test Plan:
- Reset held low 2 cycles, then released with all inputs 0: state=0, counters=0, pc_we=1, ifid_we=1, no flush.
- LDUR X11 in EX (ex_rd=11), ID reads id_rn=11 with id_use_rn=1: one cycle of pc_we=0, ifid_we=0, idex_bubble=1, state=2; the next cycle is normal; stall_cnt=1. Repeat with ex_rd=31: no stall.
- mem_valid=1 with dmem_ack low for 3 cycles: dmem_req=1 and all enables 0 for 3 cycles, state=1; the ack cycle advances; stall_cnt=3.
- br_taken pulse with REDIRECT_CYCLES=2: cycle 0 pc_sel_tgt=1, ifid_flush=1, idex_bubble=1; cycles 1-2 ifid_flush=1, state=3; cycle 3 state=0; flush_cnt=1.
- Simultaneous br_taken and load_use: branch wins, no stall, stall_cnt unchanged. br_taken while freeze: ignored until the ack cycle, then redirect.
- CNT_W=4, 20 stall cycles: stall_cnt=15 and held. Reset mid-MEMWAIT: dmem_req=0 immediately, state=0, counters=0.
